histogram_esitleme: RTL and testbench

HISTOGRAM_ESITLEME -- requirements
Module: histogram_esitleme

---
 rtl/histogram_esitleme_pkg.sv | 20 ++
 rtl/histogram_esitleme_bolme_birimi.sv | 71 +++++++
 rtl/histogram_esitleme.sv | 145 ++++++++++++++
 tb/tb_histogram_esitleme.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_esitleme_pkg.sv
// Shared constants and FSM state type for the histogram-equalisation LUT builder.
package histogram_esitleme_pkg;

  localparam int unsigned PIXEL_BIT          = 8;
  localparam int unsigned CDF_BIT_VARSAYILAN = 17;
  localparam int unsigned PAY_BIT            = 26;
  localparam int unsigned BOLME_GECIKME      = 26;
  localparam int unsigned BIN_CEVRIM         = 29;
  localparam int unsigned LUT_DERINLIK       = 256;

  typedef enum logic [2:0] {
    BOSTA,
    OKU,
    TOPLA,
    BOL,
    YAZ,
    ESLE
  } durum_e;

endpackage

// File: rtl/histogram_esitleme_bolme_birimi.sv
// Restoring divider, PAY_BIT-bit numerator / CDF_BIT-bit divisor, fixed latency.
module bolme_birimi
  import histogram_esitleme_pkg::*;
#(
  parameter int unsigned CDF_BIT = CDF_BIT_VARSAYILAN
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               basla_i,
  input  logic [PAY_BIT-1:0] pay_i,
  input  logic [CDF_BIT-1:0] payda_i,
  output logic               bitti_o,
  output logic [PAY_BIT-1:0] bolum_o
);

  logic [CDF_BIT:0]   kalan_q, kalan_d, kalan_giris, kaydir;
  logic [PAY_BIT-1:0] bolum_q, bolum_d, bolum_giris;
  logic [CDF_BIT-1:0] payda_q, payda_giris;
  logic [4:0]         sayac_q;
  logic               mesgul_q, bitti_q;

  // The start cycle already performs the first iteration so that done and
  // the final quotient appear together after BOLME_GECIKME cycles.
  always_comb begin
    kalan_giris = basla_i ? '0 : kalan_q;
    bolum_giris = basla_i ? pay_i : bolum_q;
    payda_giris = basla_i ? payda_i : payda_q;
    kaydir      = {kalan_giris[CDF_BIT-1:0], bolum_giris[PAY_BIT-1]};
    if (kaydir >= {1'b0, payda_giris}) begin
      kalan_d = kaydir - {1'b0, payda_giris};
      bolum_d = {bolum_giris[PAY_BIT-2:0], 1'b1};
    end else begin
      kalan_d = kaydir;
      bolum_d = {bolum_giris[PAY_BIT-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      kalan_q  <= '0;
      bolum_q  <= '0;
      payda_q  <= '0;
      sayac_q  <= '0;
      mesgul_q <= 1'b0;
      bitti_q  <= 1'b0;
    end else if (basla_i) begin
      kalan_q  <= kalan_d;
      bolum_q  <= bolum_d;
      payda_q  <= payda_i;
      sayac_q  <= 5'(BOLME_GECIKME - 1);
      mesgul_q <= 1'b1;
      bitti_q  <= 1'b0;
    end else if (mesgul_q) begin
      kalan_q <= kalan_d;
      bolum_q <= bolum_d;
      sayac_q <= sayac_q - 5'd1;
      if (sayac_q == 5'd1) begin
        mesgul_q <= 1'b0;
        bitti_q  <= 1'b1;
      end else begin
        bitti_q <= 1'b0;
      end
    end else begin
      bitti_q <= 1'b0;
    end
  end

  assign bitti_o = bitti_q;
  assign bolum_o = bolum_q;

endmodule

// File: rtl/histogram_esitleme.sv
// Builds a 256-entry equalisation LUT from a histogram SRAM, then maps a pixel stream.
module histogram_esitleme
  import histogram_esitleme_pkg::*;
#(
  parameter int unsigned CDF_BIT = CDF_BIT_VARSAYILAN
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 baslat_i,
  input  logic [CDF_BIT-1:0]   cdf_min_i,
  input  logic [CDF_BIT-1:0]   toplam_i,
  output logic                 rd_en_o,
  output logic [PIXEL_BIT-1:0] addr_r_o,
  input  logic [CDF_BIT-1:0]   data_out_i,
  output logic                 lut_hazir_o,
  input  logic                 pixel_gecerli_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 pixel_hazir_o,
  output logic                 pixel_gecerli_o,
  output logic [PIXEL_BIT-1:0] pixel_o
);

  durum_e               durum_q, durum_d;
  logic [PIXEL_BIT-1:0] indis_q, indis_d;
  logic [CDF_BIT-1:0]   cdf_q, cdf_d;
  logic [CDF_BIT-1:0]   cdf_min_q, cdf_min_d;
  logic [CDF_BIT-1:0]   payda_q, payda_d;
  logic [PIXEL_BIT-1:0] lut_q [LUT_DERINLIK];
  logic                 pixel_gecerli_q;
  logic [PIXEL_BIT-1:0] pixel_q;

  logic [CDF_BIT-1:0]   cdf_yeni, fark;
  logic [PAY_BIT-1:0]   pay;
  logic                 bolme_basla, bolme_bitti;
  logic [PAY_BIT-1:0]   bolum;
  logic [PIXEL_BIT-1:0] lut_deger;
  logic                 baslat_kabul, pixel_kabul;

  assign baslat_kabul = baslat_i && (durum_q == BOSTA || durum_q == ESLE);
  assign pixel_kabul  = pixel_gecerli_i && pixel_hazir_o;
  assign bolme_basla  = (durum_q == TOPLA);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) durum_q <= BOSTA;
    else         durum_q <= durum_d;
  end

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      BOSTA:   if (baslat_i) durum_d = OKU;
      OKU:     durum_d = TOPLA;
      TOPLA:   durum_d = BOL;
      BOL:     if (bolme_bitti) durum_d = YAZ;
      YAZ:     durum_d = (indis_q == '1) ? ESLE : OKU;
      ESLE:    if (baslat_i) durum_d = OKU;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    rd_en_o       = (durum_q != OKU);
    addr_r_o      = (durum_q == OKU) ? indis_q : '0;
    lut_hazir_o   = (durum_q == ESLE);
    pixel_hazir_o = (durum_q == ESLE);
  end

  // Rounded scaling: (max(cdf - cdf_min, 0) * 255 + den/2) / den.
  always_comb begin
    cdf_yeni = cdf_q + data_out_i;
    fark     = (cdf_yeni > cdf_min_q) ? (cdf_yeni - cdf_min_q) : '0;
    pay      = PAY_BIT'(fark) * PAY_BIT'(255) + PAY_BIT'(payda_q >> 1);
  end

  always_comb begin
    indis_d   = indis_q;
    cdf_d     = cdf_q;
    cdf_min_d = cdf_min_q;
    payda_d   = payda_q;
    if (baslat_kabul) begin
      indis_d   = '0;
      cdf_d     = '0;
      cdf_min_d = cdf_min_i;
      payda_d   = toplam_i - cdf_min_i;
    end else if (durum_q == TOPLA) begin
      cdf_d = cdf_yeni;
    end else if (durum_q == YAZ) begin
      indis_d = indis_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      indis_q   <= '0;
      cdf_q     <= '0;
      cdf_min_q <= '0;
      payda_q   <= '0;
    end else begin
      indis_q   <= indis_d;
      cdf_q     <= cdf_d;
      cdf_min_q <= cdf_min_d;
      payda_q   <= payda_d;
    end
  end

  bolme_birimi #(
    .CDF_BIT(CDF_BIT)
  ) u_bolme (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .basla_i (bolme_basla),
    .pay_i   (pay),
    .payda_i (payda_q),
    .bitti_o (bolme_bitti),
    .bolum_o (bolum)
  );

  always_comb begin
    if (payda_q == '0)
      lut_deger = indis_q;
    else if (|bolum[PAY_BIT-1:PIXEL_BIT])
      lut_deger = '1;
    else
      lut_deger = bolum[PIXEL_BIT-1:0];
  end

  // No reset on the table: lut_hazir_o alone qualifies its contents.
  always_ff @(posedge clk_i) begin
    if (durum_q == YAZ) lut_q[indis_q] <= lut_deger;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pixel_gecerli_q <= 1'b0;
      pixel_q         <= '0;
    end else begin
      pixel_gecerli_q <= pixel_kabul;
      if (pixel_kabul) pixel_q <= lut_q[pixel_i];
    end
  end

  assign pixel_gecerli_o = pixel_gecerli_q;
  assign pixel_o         = pixel_q;

endmodule

// File: tb/tb_histogram_esitleme.sv
// Directed self-checking bench for histogram_esitleme with a behavioural histogram SRAM.
module tb_histogram_esitleme;

  localparam int CB = 17;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          baslat_i;
  logic [CB-1:0] cdf_min_i;
  logic [CB-1:0] toplam_i;
  logic          rd_en_o;
  logic [7:0]    addr_r_o;
  logic [CB-1:0] data_out_i;
  logic          lut_hazir_o;
  logic          pixel_gecerli_i;
  logic [7:0]    pixel_i;
  logic          pixel_hazir_o;
  logic          pixel_gecerli_o;
  logic [7:0]    pixel_o;

  histogram_esitleme #(.CDF_BIT(CB)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .baslat_i        (baslat_i),
    .cdf_min_i       (cdf_min_i),
    .toplam_i        (toplam_i),
    .rd_en_o         (rd_en_o),
    .addr_r_o        (addr_r_o),
    .data_out_i      (data_out_i),
    .lut_hazir_o     (lut_hazir_o),
    .pixel_gecerli_i (pixel_gecerli_i),
    .pixel_i         (pixel_i),
    .pixel_hazir_o   (pixel_hazir_o),
    .pixel_gecerli_o (pixel_gecerli_o),
    .pixel_o         (pixel_o)
  );

  always #5 clk_i = ~clk_i;

  logic [CB-1:0] mem [256];
  always @(posedge clk_i) if (!rd_en_o) data_out_i <= mem[addr_r_o];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_lut [256];
  int cur_min, cur_n;
  int c0;

  typedef struct {
    int scen;
    int pix;
    int exp;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rd_en"}, 32'(rd_en_o), 1);
    chk({nm, "_addr"}, 32'(addr_r_o), 0);
    chk({nm, "_lut_hazir"}, 32'(lut_hazir_o), 0);
    chk({nm, "_pixel_hazir"}, 32'(pixel_hazir_o), 0);
    chk({nm, "_pixel_gecerli"}, 32'(pixel_gecerli_o), 0);
    chk({nm, "_pixel"}, 32'(pixel_o), 0);
  endtask

  task automatic set_hist(input int s);
    int cdf, den, d, e;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    cur_n = 1024;
    case (s)
      0: begin for (int i = 0; i < 256; i++) mem[i] = 4; cur_min = 4; end
      1: begin mem[77] = 1024; cur_min = 1024; end
      default: begin mem[10] = 512; mem[200] = 512; cur_min = 512; end
    endcase
    cdf_min_i = CB'(cur_min);
    toplam_i  = CB'(cur_n);
    cdf = 0;
    den = cur_n - cur_min;
    for (int i = 0; i < 256; i++) begin
      cdf += int'(mem[i]);
      if (den == 0) e = i;
      else begin
        d = (cdf > cur_min) ? cdf - cur_min : 0;
        e = (d * 255 + den / 2) / den;
        if (e > 255) e = 255;
      end
      exp_lut[i] = e;
    end
  endtask

  task automatic kick(input bit with_pix, input int pix);
    @(negedge clk_i);
    baslat_i = 1'b1;
    if (with_pix) begin
      pixel_gecerli_i = 1'b1;
      pixel_i = 8'(pix);
    end
    @(negedge clk_i);
    baslat_i = 1'b0;
    pixel_gecerli_i = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_build(input int ign_at, input int abort_at);
    int off, nrd, bad_rd, bad_hs;
    off = 0; nrd = 0; bad_rd = 0; bad_hs = 0;
    pixel_gecerli_i = 1'b1;
    pixel_i = 8'd5;
    while (1) begin
      if (rd_en_o === 1'b0) begin
        if (off != nrd * 29 || int'(addr_r_o) != nrd) bad_rd++;
        nrd++;
      end
      if (lut_hazir_o === 1'b1) break;
      if (off >= 1 && (pixel_hazir_o !== 1'b0 || pixel_gecerli_o !== 1'b0)) bad_hs++;
      if (off == abort_at) break;
      if (off > 8000) break;
      baslat_i = (off == ign_at);
      @(negedge clk_i);
      off++;
    end
    pixel_gecerli_i = 1'b0;
    baslat_i = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_offset", 32'(off), 32'(abort_at));
      chk("abort_rd_count", 32'(nrd), 104);
      chk("abort_rd_order", 32'(bad_rd), 0);
      #2 rstn_i = 1'b0;
      #1 check_reset_outputs("midbuild_reset");
      @(negedge clk_i);
      rstn_i = 1'b1;
    end else begin
      chk("build_latency", 32'(off), 7424);
      chk("build_rd_count", 32'(nrd), 256);
      chk("build_rd_order", 32'(bad_rd), 0);
      chk("build_handshake_idle", 32'(bad_hs), 0);
      chk("build_cycle_counter", 32'(cyc - c0), 7424);
    end
  endtask

  task automatic apply_pix(input int p, output logic v, output logic [7:0] o);
    pixel_gecerli_i = 1'b1;
    pixel_i = 8'(p);
    @(negedge clk_i);
    pixel_gecerli_i = 1'b0;
    v = pixel_gecerli_o;
    o = pixel_o;
  endtask

  task automatic run_vectors(input int s);
    logic v;
    logic [7:0] o;
    for (int k = 0; k < 10; k++) begin
      if (vecs[k].scen == s) begin
        apply_pix(vecs[k].pix, v, o);
        chk($sformatf("vec%0d_valid", k), 32'(v), 1);
        chk($sformatf("vec%0d_pixel%0d", k, vecs[k].pix), 32'(o), 32'(vecs[k].exp));
      end
    end
  endtask

  task automatic sweep(input string nm);
    int errs;
    errs = 0;
    for (int p = 0; p < 256; p++) begin
      pixel_gecerli_i = 1'b1;
      pixel_i = 8'(p);
      @(negedge clk_i);
      if (pixel_gecerli_o !== 1'b1 || int'(pixel_o) != exp_lut[p]) errs++;
    end
    pixel_gecerli_i = 1'b0;
    @(negedge clk_i);
    chk({nm, "_valid_drop"}, 32'(pixel_gecerli_o), 0);
    chk({nm, "_lut_sweep_errs"}, 32'(errs), 0);
  endtask

  initial begin
    logic v;
    logic [7:0] o;

    vecs[0] = '{0, 100, 100};
    vecs[1] = '{0, 0, 0};
    vecs[2] = '{0, 255, 255};
    vecs[3] = '{1, 77, 77};
    vecs[4] = '{1, 0, 0};
    vecs[5] = '{1, 255, 255};
    vecs[6] = '{2, 10, 0};
    vecs[7] = '{2, 200, 255};
    vecs[8] = '{2, 199, 0};
    vecs[9] = '{2, 255, 255};

    rstn_i = 1'b0;
    baslat_i = 1'b0;
    pixel_gecerli_i = 1'b0;
    pixel_i = '0;
    cdf_min_i = '0;
    toplam_i = '0;
    #23 check_reset_outputs("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("idle_pixel_hazir", 32'(pixel_hazir_o), 0);

    // Uniform histogram: identity mapping.
    set_hist(0);
    kick(1'b0, 0);
    wait_build(-1, -1);
    run_vectors(0);
    sweep("uniform");

    // Single-value image, den == 0: identity, same timing.
    set_hist(1);
    kick(1'b0, 0);
    wait_build(-1, -1);
    run_vectors(1);
    sweep("single");

    // Two-spike image: reset mid-build, then rebuild with an ignored baslat_i.
    set_hist(2);
    kick(1'b0, 0);
    wait_build(-1, 3000);
    kick(1'b0, 0);
    wait_build(1000, -1);
    run_vectors(2);
    sweep("two_spike");

    // Restart from ESLE with a pixel in the same cycle: old LUT still used.
    set_hist(0);
    kick(1'b1, 200);
    chk("restart_old_valid", 32'(pixel_gecerli_o), 1);
    chk("restart_old_pixel", 32'(pixel_o), 255);
    chk("restart_lut_hazir_drop", 32'(lut_hazir_o), 0);
    chk("restart_pixel_hazir_drop", 32'(pixel_hazir_o), 0);
    wait_build(-1, -1);
    apply_pix(100, v, o);
    chk("restart_new_valid", 32'(v), 1);
    chk("restart_new_pixel", 32'(o), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
